// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with shared prescaler/counter and shadowed,
// boundary-synchronised period/duty updates.
// Ports: clk, rst (sync, active-high), en, prescale[15:0], load,
//        period[WIDTH-1:0], duty[CHANNELS*WIDTH-1:0],
//        pwm_out[CHANNELS-1:0], period_end.
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [15:0]               prescale,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end
);

  localparam logic ACT_LVL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  logic [15:0]               pre_cnt;
  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          period_act;
  logic [WIDTH-1:0]          period_sh;
  logic [CHANNELS*WIDTH-1:0] duty_act;
  logic [CHANNELS*WIDTH-1:0] duty_sh;
  logic                      pending;

  logic                      tick;
  logic                      boundary;
  logic [CHANNELS-1:0]       cmp;

  assign tick     = en && (pre_cnt == prescale);
  assign boundary = tick && (cnt == period_act);

  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp[i] = cnt < duty_act[i*WIDTH +: WIDTH];
    end
  end

  // Prescaler, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      pwm_out    <= {CHANNELS{~ACT_LVL}};
      period_end <= 1'b0;
    end else if (!en) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      pwm_out    <= {CHANNELS{~ACT_LVL}};
      period_end <= 1'b0;
    end else begin
      pre_cnt    <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) begin
        cnt <= boundary ? '0 : cnt + WIDTH'(1);
      end
      pwm_out    <= ACT_LVL ? cmp : ~cmp;
      period_end <= boundary;
    end
  end

  // Shadow/active registers: a load takes effect immediately when the
  // counter is idle or at a boundary, otherwise it waits for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_act <= '1;
      duty_act   <= '0;
      period_sh  <= '0;
      duty_sh    <= '0;
      pending    <= 1'b0;
    end else if (load) begin
      period_sh <= period;
      duty_sh   <= duty;
      if (!en || boundary) begin
        period_act <= period;
        duty_act   <= duty;
        pending    <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      period_act <= period_sh;
      duty_act   <= duty_sh;
      pending    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: cycle model plus directed and random
// stimulus, checking an active-high and an active-low instance together.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] prescale = '0;
  logic [7:0]  period = '0;
  logic [31:0] duty = '0;
  logic [3:0]  pwm0;
  logic [3:0]  pwm1;
  logic        pe0;
  logic        pe1;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .load(load),
    .period(period), .duty(duty), .pwm_out(pwm0), .period_end(pe0)
  );

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .load(load),
    .period(period), .duty(duty), .pwm_out(pwm1), .period_end(pe1)
  );

  int checks = 0;
  int failures = 0;

  // model state
  int m_pre, m_cnt, m_per, s_per, m_pend;
  int m_duty[4];
  int s_duty[4];
  logic [3:0] e_pwm;
  logic       e_pe;

  // accumulators of observed DUT activity
  int hi[4];
  int pe_n;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic take_inputs_active();
    m_per = int'(period);
    s_per = int'(period);
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = int'(duty[i*8 +: 8]);
      s_duty[i] = m_duty[i];
    end
    m_pend = 0;
  endtask

  task automatic step();
    bit tk, bnd;
    if (rst) begin
      m_pre = 0; m_cnt = 0; m_pend = 0; m_per = 255; s_per = 0;
      for (int i = 0; i < 4; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
      e_pwm = 4'h0; e_pe = 1'b0;
      return;
    end
    if (!en) begin
      e_pwm = 4'h0; e_pe = 1'b0;
      if (load) take_inputs_active();
      m_pre = 0; m_cnt = 0;
      return;
    end
    tk  = (m_pre == int'(prescale));
    bnd = tk && (m_cnt == m_per);
    for (int i = 0; i < 4; i++) e_pwm[i] = (m_cnt < m_duty[i]);
    e_pe = bnd;
    if (load) begin
      if (bnd) take_inputs_active();
      else begin
        s_per = int'(period);
        for (int i = 0; i < 4; i++) s_duty[i] = int'(duty[i*8 +: 8]);
        m_pend = 1;
      end
    end else if (bnd && m_pend == 1) begin
      m_per = s_per;
      for (int i = 0; i < 4; i++) m_duty[i] = s_duty[i];
      m_pend = 0;
    end
    m_pre = tk ? 0 : ((m_pre + 1) & 32'hFFFF);
    if (tk) m_cnt = bnd ? 0 : m_cnt + 1;
  endtask

  task automatic cyc();
    logic [3:0] inv;
    @(posedge clk);
    step();
    #1;
    inv = ~e_pwm;
    chk("pwm_high_act", int'(pwm0), int'(e_pwm));
    chk("pwm_low_act", int'(pwm1), int'(inv));
    chk("pe_high_act", int'(pe0), int'(e_pe));
    chk("pe_low_act", int'(pe1), int'(e_pe));
    for (int i = 0; i < 4; i++) if (pwm0[i]) hi[i]++;
    if (pe0) pe_n++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    pe_n = 0;
  endtask

  task automatic wait_cnt(int v);
    int k;
    k = 0;
    while (m_cnt != v && k < 2000) begin cyc(); k++; end
    if (m_cnt != v) chk("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic wait_pe(output int n);
    n = 0;
    do begin cyc(); n++; end while (!e_pe && n < 2000);
    if (!e_pe) chk("wait_pe_timeout", 0, 1);
  endtask

  task automatic set_duty(int d0, int d1, int d2, int d3);
    duty = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endtask

  initial begin
    int n;
    int r;
    clr();
    // reset with en/load asserted
    rst = 1; en = 1; load = 1; period = 8'd5; set_duty(1, 2, 3, 4);
    cyc();
    cyc();
    chk("reset_pwm_high_act", int'(pwm0), 0);
    chk("reset_pwm_low_act", int'(pwm1), 15);
    chk("reset_pe", int'(pe0), 0);
    rst = 0; en = 0; load = 0;
    cyc();

    // basic run
    prescale = 0; period = 8'd9; set_duty(0, 3, 9, 10); load = 1;
    cyc();
    load = 0; en = 1;
    wait_pe(n);
    clr();
    run(10);
    chk("basic_ch0", hi[0], 0);
    chk("basic_ch1", hi[1], 3);
    chk("basic_ch2", hi[2], 9);
    chk("basic_ch3", hi[3], 10);
    chk("basic_pe", pe_n, 1);

    // deferred duty update
    wait_cnt(5);
    set_duty(0, 7, 9, 10); load = 1;
    cyc();
    load = 0;
    clr();
    wait_pe(n);
    chk("deferred_old_tail", hi[1], 0);
    clr();
    run(10);
    chk("deferred_new_ch1", hi[1], 7);
    chk("deferred_pe", pe_n, 1);

    // load coinciding with a boundary
    wait_cnt(9);
    period = 8'd4; load = 1;
    cyc();
    load = 0;
    wait_pe(n);
    wait_pe(n);
    chk("boundary_load_len", n, 5);

    // prescaler
    en = 0; period = 8'd9; set_duty(0, 3, 9, 10); prescale = 3; load = 1;
    cyc();
    load = 0; en = 1;
    wait_pe(n);
    clr();
    wait_pe(n);
    chk("presc_len", n, 40);
    chk("presc_ch1", hi[1], 12);
    chk("presc_ch3", hi[3], 40);

    // mid-operation reset with pending load
    en = 0; prescale = 0;
    cyc();
    en = 1;
    wait_cnt(2);
    period = 8'd9; set_duty(5, 5, 5, 5); load = 1;
    cyc();
    load = 0;
    wait_cnt(6);
    rst = 1;
    cyc();
    rst = 0;
    chk("midrst_pwm", int'(pwm0), 0);
    clr();
    run(20);
    chk("midrst_duty_zero", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // disable mid-period
    en = 0; period = 8'd9; set_duty(0, 3, 9, 10); load = 1;
    cyc();
    load = 0; en = 1;
    wait_cnt(4);
    en = 0;
    cyc();
    chk("dis_pwm", int'(pwm0), 0);
    clr();
    run(20);
    chk("dis_pe", pe_n, 0);
    chk("dis_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // random
    en = 1;
    for (int k = 0; k < 4000; k++) begin
      r = int'($urandom_range(0, 999));
      rst = (r < 3);
      if (r < 20) en = ~en;
      load = ($urandom_range(0, 29) == 0);
      if (load) begin
        period = 8'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++)
          duty[i*8 +: 8] = 8'($urandom_range(0, int'(period) + 2));
      end
      if (!en && $urandom_range(0, 3) == 0)
        prescale = 16'($urandom_range(0, 2));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
